// File: rtl/handshaking_top_design.sv
// handshaking_top_design: a sender FSM and a receiver FSM joined by a
// registered valid/ready handshake and a tx_data holding register.
// A word moves on any rising edge where valid and ready are both 1.
// Optional macro HANDSHAKE_RX_BUSY_EN adds a receiver busy period of
// BUSY_CYCLES cycles after each transfer. When the macro is undefined,
// ready stays high from R_READY until reset.
//
// Sender states
//   state  | meaning
//   S_IDLE | valid=0, capture data_in on the next edge
//   S_SEND | valid=1, hold tx_data until the transfer edge
// Receiver states
//   state   | meaning
//   R_INIT  | ready=0, first cycle out of reset
//   R_READY | ready=1, accept tx_data on the transfer edge
//   R_BUSY  | ready=0, counting down the busy period (busy build only)
module handshaking_top_design #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUSY_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] R_INIT  = 2'd0;
  localparam logic [1:0] R_READY = 2'd1;
`ifdef HANDSHAKE_RX_BUSY_EN
  localparam logic [1:0] R_BUSY  = 2'd2;
  localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYCLES - 1);
`endif

  if (BUSY_CYCLES < 1 || BUSY_CYCLES > 15) begin : g_bad_busy
    $error("BUSY_CYCLES must be in 1..15");
  end

  logic [1:0]            s_state_q, s_state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [1:0]            r_state_q, r_state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
`ifdef HANDSHAKE_RX_BUSY_EN
  logic [3:0]            cnt_q, cnt_d;
`endif
  logic                  xfer;

  assign xfer     = valid_q & ready_q;
  assign valid    = valid_q;
  assign ready    = ready_q;
  assign data_out = data_out_q;

  // Sender next state: capture once in S_IDLE, hold until the transfer edge.
  always_comb begin
    s_state_d = s_state_q;
    valid_d   = valid_q;
    tx_data_d = tx_data_q;
    case (s_state_q)
      S_IDLE: begin
        tx_data_d = data_in;
        valid_d   = 1'b1;
        s_state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          valid_d   = 1'b0;
          s_state_d = S_IDLE;
        end
      end
      default: begin
        valid_d   = 1'b0;
        tx_data_d = '0;
        s_state_d = S_IDLE;
      end
    endcase
  end

  // Receiver next state: accept on the transfer edge, optionally go busy.
  always_comb begin
    r_state_d  = r_state_q;
    ready_d    = ready_q;
    data_out_d = data_out_q;
`ifdef HANDSHAKE_RX_BUSY_EN
    cnt_d      = cnt_q;
`endif
    case (r_state_q)
      R_INIT: begin
        ready_d   = 1'b1;
        r_state_d = R_READY;
      end
      R_READY: begin
        if (xfer) begin
          data_out_d = tx_data_q;
`ifdef HANDSHAKE_RX_BUSY_EN
          ready_d    = 1'b0;
          cnt_d      = BUSY_LOAD;
          r_state_d  = R_BUSY;
`endif
        end
      end
`ifdef HANDSHAKE_RX_BUSY_EN
      R_BUSY: begin
        if (cnt_q == 4'd0) begin
          ready_d   = 1'b1;
          r_state_d = R_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: begin
        ready_d    = 1'b0;
        data_out_d = '0;
`ifdef HANDSHAKE_RX_BUSY_EN
        cnt_d      = 4'd0;
`endif
        r_state_d  = R_INIT;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state_q  <= S_IDLE;
      valid_q    <= 1'b0;
      tx_data_q  <= '0;
      r_state_q  <= R_INIT;
      ready_q    <= 1'b0;
      data_out_q <= '0;
`ifdef HANDSHAKE_RX_BUSY_EN
      cnt_q      <= 4'd0;
`endif
    end else begin
      s_state_q  <= s_state_d;
      valid_q    <= valid_d;
      tx_data_q  <= tx_data_d;
      r_state_q  <= r_state_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
`ifdef HANDSHAKE_RX_BUSY_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_handshaking_top_design.sv
// Directed bench for handshaking_top_design (default parameters).
// Covers both builds of the HANDSHAKE_RX_BUSY_EN macro.
module tb_handshaking_top_design;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h5A;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;

  int n_checks = 0;
  int n_err    = 0;

  logic       pv, pr;
  logic [7:0] pd;
  logic [7:0] vals [4];

  handshaking_top_design #(.DATA_WIDTH(8), .BUSY_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic v, input logic r, input logic [7:0] d);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
    chk({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
    chk({tag, "_data"},  {24'd0, data_out}, {24'd0, d});
  endtask

  initial begin
    vals[0] = 8'h5A; vals[1] = 8'hA5; vals[2] = 8'h00; vals[3] = 8'hFF;

    // Reset held for three edges.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk3("reset", 1'b0, 1'b0, 8'h00);
    end

`ifdef HANDSHAKE_RX_BUSY_EN
    data_in = 8'h5A;
    rst = 1'b0;
    step(); chk3("rel_e1", 1'b1, 1'b1, 8'h00);
    step(); chk3("rel_e2", 1'b0, 1'b0, 8'h5A);
    data_in = 8'hC3;
    step(); chk3("busy_e3", 1'b1, 1'b0, 8'h5A);
    data_in = 8'hA5;                       // changed while valid=1, ready=0
    step(); chk3("busy_e4", 1'b1, 1'b1, 8'h5A);
    step(); chk3("capt_e5", 1'b0, 1'b0, 8'hC3);
    step(); chk3("capt_e6", 1'b1, 1'b0, 8'hC3);
    step(); chk3("capt_e7", 1'b1, 1'b1, 8'hC3);
    step(); chk3("capt_e8", 1'b0, 1'b0, 8'hA5);
`else
    data_in = 8'h3C;
    rst = 1'b0;
    step(); chk3("rel_e1", 1'b1, 1'b1, 8'h00);
    step(); chk3("rel_e2", 1'b0, 1'b1, 8'h3C);
    for (int i = 3; i <= 10; i++) begin
      step();
      chk3("nobusy_run", ((i % 2) == 1), 1'b1, 8'h3C);
    end
    data_in = 8'hA5;
    step(); chk3("capt_e11", 1'b1, 1'b1, 8'h3C);
    data_in = 8'h11;                       // changed while valid=1
    step(); chk3("capt_e12", 1'b0, 1'b1, 8'hA5);
    step(); chk3("capt_e13", 1'b1, 1'b1, 8'hA5);
    step(); chk3("capt_e14", 1'b0, 1'b1, 8'h11);
`endif

    // Data steps: change right after a transfer edge, follow within 4 cycles,
    // and data_out must never move without valid&ready.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 6 && valid !== 1'b0; k++) step();
      chk("sync_idle", {31'd0, valid}, 32'd0);
      data_in = vals[v];
      for (int c = 1; c <= 12; c++) begin
        pv = valid; pr = ready; pd = data_out;
        step();
        if (!(pv && pr)) chk("hold_no_xfer", {24'd0, data_out}, {24'd0, pd});
        if (c == 4) chk("follow", {24'd0, data_out}, {24'd0, vals[v]});
      end
    end

`ifdef HANDSHAKE_RX_BUSY_EN
    // Reset during the busy period.
    for (int k = 0; k < 6 && ready !== 1'b0; k++) step();
    chk("sync_busy", {31'd0, ready}, 32'd0);
`else
    // Reset while a word is in flight.
    for (int k = 0; k < 6 && valid !== 1'b1; k++) step();
    chk("sync_send", {31'd0, valid}, 32'd1);
`endif
    data_in = 8'h96;
    rst = 1'b1;
    step(); chk3("midrst", 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step(); chk3("resume_e1", 1'b1, 1'b1, 8'h00);
`ifdef HANDSHAKE_RX_BUSY_EN
    step(); chk3("resume_e2", 1'b0, 1'b0, 8'h96);
`else
    step(); chk3("resume_e2", 1'b0, 1'b1, 8'h96);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/handshaking_top_design.md
HANDSHAKING_TOP_DESIGN -- requirements
Module: handshaking_top_design

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of data_in and data_out.
REQ-002 Parameter BUSY_CYCLES, default 2, range 1..15, SHALL set the receiver busy period after each transfer.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 data_in  input  DATA_WIDTH  SHALL be the source word, sampled by the internal sender.
REQ-006 data_out  output  DATA_WIDTH  SHALL be the last word accepted by the internal receiver, registered.
REQ-007 valid  output  1  SHALL be the sender-to-receiver valid, registered, exported for observation.
REQ-008 ready  output  1  SHALL be the receiver-to-sender ready, registered, exported for observation.

Function
REQ-009 The block SHALL contain one sender FSM and one receiver FSM, linked only by valid, ready and an internal tx_data register.
REQ-010 A transfer SHALL occur on any rising edge where valid=1 and ready=1; no other condition moves data.
REQ-011 Sender states: S_IDLE (valid=0) and S_SEND (valid=1).
REQ-012 S_IDLE: next edge SHALL load tx_data<=data_in, set valid<=1, enter S_SEND.
REQ-013 S_SEND: tx_data and valid SHALL stay stable until the transfer edge; data_in changes during S_SEND SHALL be ignored.
REQ-014 S_SEND on transfer edge: valid<=0, enter S_IDLE.
REQ-015 Receiver states: R_INIT (ready=0), R_READY (ready=1), R_BUSY (ready=0).
REQ-016 R_INIT: next edge SHALL set ready<=1 and enter R_READY.
REQ-017 R_READY on transfer edge: data_out<=tx_data, ready<=0, load busy counter, enter R_BUSY.
REQ-018 R_BUSY: ready SHALL remain 0 for exactly BUSY_CYCLES cycles after the transfer edge, then ready<=1 and enter R_READY.
REQ-019 data_out SHALL change only on a transfer edge or reset; otherwise it holds.
REQ-020 Steady state with BUSY_CYCLES=2 SHALL give one transfer every 3 cycles.
REQ-021 Transfer latency: data_in sampled at edge N SHALL appear on data_out at edge N+1 at the earliest.
REQ-022 Illegal or unused state encodings SHALL recover to the reset state on the next edge.

Reset
REQ-023 While rst=1 at a rising edge: valid=0, ready=0, data_out=0, tx_data=0, sender S_IDLE, receiver R_INIT, busy counter=0.
REQ-024 Reset asserted mid-transfer or mid-busy SHALL discard the in-flight word; data_out SHALL be 0 after that edge.
REQ-025 First edge with rst=0: sender enters S_SEND (valid=1); receiver enters R_READY (ready=1); the first transfer SHALL occur on the second edge.
REQ-026 Outputs before the first reset edge are undefined; no requirement applies.

Configuration
REQ-027 Macro HANDSHAKE_RX_BUSY_EN defined: receiver SHALL implement R_BUSY per REQ-017/REQ-018.
REQ-028 Macro HANDSHAKE_RX_BUSY_EN undefined: R_BUSY and counter SHALL be omitted, ready SHALL stay 1 from R_READY until reset, and throughput SHALL be one transfer every 2 cycles (sender-limited).

Verification
REQ-029 rst=1 for 3 edges, data_in=8'h5A -> valid=0, ready=0, data_out=8'h00 after each reset edge.
REQ-030 Release reset, data_in=8'h5A -> edge 1: valid=1, ready=1; edge 2: data_out=8'h5A, valid=0, ready=0; ready=1 again 2 cycles later.
REQ-031 data_in steps 8'h5A->8'hA5->8'h00->8'hFF, each held at least 10 cycles -> data_out follows each value within 4 cycles; no transfer occurs while ready=0.
REQ-032 Assert rst for one edge while in R_BUSY -> data_out=8'h00, valid=0, ready=0; normal sequence per REQ-025 resumes.
REQ-033 Change data_in while valid=1 and ready=0 -> data_out receives the word captured at valid rise, not the new value.
REQ-034 Build without HANDSHAKE_RX_BUSY_EN, data_in constant 8'h3C -> ready stays 1 after the first edge; valid toggles every cycle; data_out=8'h3C.
